// File: rtl/spi_responder.sv
// spi_responder: SPI mode-0 responder clocked entirely by clk_52.
// SS/SCLK/MOSI are synchronized into clk_52 and edge-detected there, so the
// SPI clock must stay at or below clk_52/8.
// Ports:
//   clk_52, RESET_N        system clock, async-assert active-low reset
//   SS, SCLK, MOSI, MISO   SPI bus (card-side master drives SS/SCLK/MOSI)
//   INT                    registered (rx_valid | irq_req)
//   tx_data/valid/ready    one-byte TX holding register, valid/ready handshake
//   rx_data/valid/ready    RX FIFO head, valid/ready pop handshake
//   irq_req                local interrupt request
//   status, status_clr     sticky {aborted_byte, tx_underrun, rx_overflow}
module spi_responder #(
    parameter int RX_DEPTH = 4
) (
    input  logic       clk_52,
    input  logic       RESET_N,
    input  logic       SS,
    input  logic       SCLK,
    input  logic       MOSI,
    output logic       MISO,
    output logic       INT,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic       irq_req,
    output logic [2:0] status,
    input  logic       status_clr
);
    localparam int AW = $clog2(RX_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t      state, state_nxt;
    logic [2:0]  ss_q, sclk_q;
    logic [1:0]  mosi_q;
    logic [1:0]  fill;
    logic        armed;
    logic [7:0]  tx_sr, rx_sr, hold_data;
    logic        hold_full;
    logic [2:0]  bit_cnt;
    logic        push_pend;
    logic        int_q;
    logic [7:0]  mem [RX_DEPTH];
    logic [AW:0] wptr, rptr;

    // Edge detection on the synchronized value ([1]) vs. its delayed copy ([2]).
    // A falling SS only counts once the responder has seen SS high after reset,
    // so a reset released in the middle of a frame does not start a bogus one.
    logic ss_fall, ss_rise, sclk_rise, sclk_fall;
    assign ss_fall   = armed & ss_q[2] & ~ss_q[1];
    assign ss_rise   = ~ss_q[2] & ss_q[1];
    assign sclk_rise = ~sclk_q[2] & sclk_q[1];
    assign sclk_fall = sclk_q[2] & ~sclk_q[1];

    logic in_shift, tx_load, tx_shift, rx_shift, abort, tx_accept;
    assign in_shift  = (state == SHIFT);
    // Bit counter at 0 on a falling edge means a byte just completed: reload
    // instead of shifting. No falling edge precedes the first rise in mode 0.
    assign tx_load   = (state == LOAD) | (in_shift & ~ss_rise & sclk_fall & (bit_cnt == 3'd0));
    assign tx_shift  = in_shift & ~ss_rise & sclk_fall & (bit_cnt != 3'd0);
    assign rx_shift  = in_shift & ~ss_rise & sclk_rise;
    assign abort     = in_shift & ss_rise & (bit_cnt != 3'd0);
    assign tx_accept = tx_valid & ~hold_full;

    logic empty, full, pop, push_ok, ovf;
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) & (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop     = ~empty & rx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok = push_pend & (~full | pop);
    assign ovf     = push_pend & full & ~pop;

    assign MISO     = ~ss_q[1] & tx_sr[7];
    assign INT      = int_q;
    assign tx_ready = ~hold_full;
    assign rx_valid = ~empty;
    assign rx_data  = empty ? 8'h00 : mem[rptr[AW-1:0]];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ss_fall) state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (ss_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_52 or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            ss_q      <= 3'b111;
            sclk_q    <= 3'b000;
            mosi_q    <= 2'b00;
            fill      <= 2'b00;
            armed     <= 1'b0;
            tx_sr     <= 8'h00;
            rx_sr     <= 8'h00;
            hold_data <= 8'h00;
            hold_full <= 1'b0;
            bit_cnt   <= 3'd0;
            push_pend <= 1'b0;
            int_q     <= 1'b0;
            wptr      <= '0;
            rptr      <= '0;
            status    <= 3'b000;
        end else begin
            state  <= state_nxt;
            ss_q   <= {ss_q[1:0], SS};
            sclk_q <= {sclk_q[1:0], SCLK};
            mosi_q <= {mosi_q[0], MOSI};
            // fill[1] marks that ss_q[1] now holds a real sample of SS.
            fill   <= {fill[0], 1'b1};
            armed  <= armed | (fill[1] & ss_q[1]);

            if (tx_load)
                tx_sr <= hold_full ? hold_data : 8'hFF;
            else if (tx_shift)
                tx_sr <= {tx_sr[6:0], 1'b0};

            // A load and an accept in one cycle: the load sees the old
            // (empty) register, the new byte lands and stays.
            if (tx_accept) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
            end else if (tx_load) begin
                hold_full <= 1'b0;
            end

            if (abort) begin
                bit_cnt <= 3'd0;
            end else if (rx_shift) begin
                rx_sr   <= {rx_sr[6:0], mosi_q[1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            push_pend <= rx_shift & (bit_cnt == 3'd7);

            if (push_ok) wptr <= wptr + PTR_ONE;
            if (pop)     rptr <= rptr + PTR_ONE;

            int_q  <= ~empty | irq_req;
            // Setting events take priority over a coincident clear.
            status <= (status & ~{3{status_clr}}) | {abort, tx_load & ~hold_full, ovf};
        end
    end

    // FIFO storage needs no reset: rx_data is forced to 0 while empty.
    always_ff @(posedge clk_52) begin
        if (push_ok) mem[wptr[AW-1:0]] <= rx_sr;
    end
endmodule
